// File: rtl/up_down_counter_mod.sv
// Modulo-N up/down counter with parallel load, synchronous clear, wrap/saturate mode
// and registered terminal-count status (at_zero, at_max, wrap pulse).
module up_down_counter_mod #(
    parameter int unsigned      WIDTH    = 8,
    parameter longint unsigned  MODULO   = 256,
    parameter int unsigned      SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 64'd1);
    localparam bit               SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_at_zero;
    logic             r_at_max;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;

    // Next count and wrap flag; increments/decrements only happen strictly inside the
    // range, so the WIDTH-bit arithmetic can never overflow, even when MODULO = 2**WIDTH.
    always_comb begin
        w_cnt_nxt  = r_count;
        w_wrap_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (load) begin
            w_cnt_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (r_count == MAX_CNT) begin
                    w_wrap_nxt = 1'b1;
                    w_cnt_nxt  = SAT ? r_count : '0;
                end else begin
                    w_cnt_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_wrap_nxt = 1'b1;
                    w_cnt_nxt  = SAT ? r_count : MAX_CNT;
                end else begin
                    w_cnt_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // Status flags are registered from the next count so they always match the count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_at_zero <= 1'b1;
            r_at_max  <= 1'b0;
        end else begin
            r_count   <= w_cnt_nxt;
            r_wrap    <= w_wrap_nxt;
            r_at_zero <= (w_cnt_nxt == '0);
            r_at_max  <= (w_cnt_nxt == MAX_CNT);
        end
    end

    assign count   = r_count;
    assign wrap    = r_wrap;
    assign at_zero = r_at_zero;
    assign at_max  = r_at_max;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed self-checking bench for up_down_counter_mod across several
// WIDTH/MODULO/SATURATE configurations sharing one clock and reset.
module tb_up_down_counter_mod;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // a: 8-bit modulo-256 wrap
    logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 0;
    logic [7:0] a_lv = '0, a_count;
    logic       a_zero, a_max, a_wrap;
    // b: 8-bit modulo-10 wrap
    logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 0;
    logic [7:0] b_lv = '0, b_count;
    logic       b_zero, b_max, b_wrap;
    // c: 4-bit modulo-10 saturate
    logic       c_clr = 0, c_load = 0, c_en = 0, c_up = 0;
    logic [3:0] c_lv = '0, c_count;
    logic       c_zero, c_max, c_wrap;
    // d: 4-bit modulo-16 wrap
    logic       d_clr = 0, d_load = 0, d_en = 0, d_up = 0;
    logic [3:0] d_lv = '0, d_count;
    logic       d_zero, d_max, d_wrap;
    // e: 1-bit modulo-2 wrap
    logic       e_clr = 0, e_load = 0, e_en = 0, e_up = 0;
    logic [0:0] e_lv = '0, e_count;
    logic       e_zero, e_max, e_wrap;

    up_down_counter_mod #(.WIDTH(8), .MODULO(256), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_lv), .en(a_en),
        .up_dn(a_up), .count(a_count), .at_zero(a_zero), .at_max(a_max), .wrap(a_wrap));
    up_down_counter_mod #(.WIDTH(8), .MODULO(10), .SATURATE(0)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_lv), .en(b_en),
        .up_dn(b_up), .count(b_count), .at_zero(b_zero), .at_max(b_max), .wrap(b_wrap));
    up_down_counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_lv), .en(c_en),
        .up_dn(c_up), .count(c_count), .at_zero(c_zero), .at_max(c_max), .wrap(c_wrap));
    up_down_counter_mod #(.WIDTH(4), .MODULO(16), .SATURATE(0)) u_d (
        .clk(clk), .rst(rst), .clr(d_clr), .load(d_load), .load_val(d_lv), .en(d_en),
        .up_dn(d_up), .count(d_count), .at_zero(d_zero), .at_max(d_max), .wrap(d_wrap));
    up_down_counter_mod #(.WIDTH(1), .MODULO(2), .SATURATE(0)) u_e (
        .clk(clk), .rst(rst), .clr(e_clr), .load(e_load), .load_val(e_lv), .en(e_en),
        .up_dn(e_up), .count(e_count), .at_zero(e_zero), .at_max(e_max), .wrap(e_wrap));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_zero",  32'(a_zero),  32'd1);
        chk("rst_max",   32'(a_max),   32'd0);
        chk("rst_wrap",  32'(a_wrap),  32'd0);
        chk("rst_c_zero", 32'(c_zero), 32'd1);
        rst = 1'b1;

        // Modulo-256 up count through one wrap
        a_en = 1; a_up = 1;
        for (int k = 1; k <= 260; k++) begin
            step();
            chk("m256_count", 32'(a_count), 32'(k % 256));
            chk("m256_wrap",  32'(a_wrap),  32'(k == 256));
            if (k == 255) chk("m256_max", 32'(a_max), 32'd1);
            if (k == 256) chk("m256_zero", 32'(a_zero), 32'd1);
        end
        a_en = 0;

        // Modulo-10 down count from 0
        b_en = 1; b_up = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("m10dn_count", 32'(b_count), 32'((20 - k) % 10));
            chk("m10dn_wrap",  32'(b_wrap),  32'(k == 1 || k == 11));
            chk("m10dn_max",   32'(b_max),   32'(k == 1 || k == 11));
        end
        b_en = 0;

        // Saturating modulo-10: load 7 then up five times
        c_load = 1; c_lv = 4'd7;
        step();
        chk("sat_load", 32'(c_count), 32'd7);
        c_load = 0; c_en = 1; c_up = 1;
        step(); chk("sat_up1", 32'(c_count), 32'd8); chk("sat_w1", 32'(c_wrap), 32'd0);
        step(); chk("sat_up2", 32'(c_count), 32'd9); chk("sat_w2", 32'(c_wrap), 32'd0);
        chk("sat_max", 32'(c_max), 32'd1);
        step(); chk("sat_up3", 32'(c_count), 32'd9); chk("sat_w3", 32'(c_wrap), 32'd1);
        step(); chk("sat_up4", 32'(c_count), 32'd9); chk("sat_w4", 32'(c_wrap), 32'd1);
        step(); chk("sat_up5", 32'(c_count), 32'd9); chk("sat_w5", 32'(c_wrap), 32'd1);
        c_en = 0;
        step(); chk("sat_idle_w", 32'(c_wrap), 32'd0); chk("sat_idle", 32'(c_count), 32'd9);
        // Saturating down from 1
        c_load = 1; c_lv = 4'd1;
        step(); chk("sat_ld1", 32'(c_count), 32'd1);
        c_load = 0; c_en = 1; c_up = 0;
        step(); chk("sat_dn1", 32'(c_count), 32'd0); chk("sat_dw1", 32'(c_wrap), 32'd0);
        step(); chk("sat_dn2", 32'(c_count), 32'd0); chk("sat_dw2", 32'(c_wrap), 32'd1);
        chk("sat_dzero", 32'(c_zero), 32'd1);
        c_en = 0;

        // Priority clr > load > en, and load clamping
        b_load = 1; b_lv = 8'd5;
        step(); chk("pri_ld5", 32'(b_count), 32'd5);
        b_clr = 1; b_load = 1; b_lv = 8'd7; b_en = 1; b_up = 1;
        step(); chk("pri_clr", 32'(b_count), 32'd0); chk("pri_clr_w", 32'(b_wrap), 32'd0);
        b_clr = 0; b_lv = 8'd3;
        step(); chk("pri_ld3", 32'(b_count), 32'd3);
        b_lv = 8'd200;
        step(); chk("clamp200", 32'(b_count), 32'd9); chk("clamp_max", 32'(b_max), 32'd1);
        b_lv = 8'd10;
        step(); chk("clamp10", 32'(b_count), 32'd9); chk("clamp_w", 32'(b_wrap), 32'd0);
        b_lv = 8'd0;
        step(); chk("ld0", 32'(b_count), 32'd0);
        b_load = 0;
        step(); chk("b_inc", 32'(b_count), 32'd1);
        b_en = 0;

        // Direction flip at modulo-16
        d_load = 1; d_lv = 4'd14;
        step(); chk("flip_ld", 32'(d_count), 32'd14);
        d_load = 0; d_en = 1; d_up = 1;
        step(); chk("flip_up", 32'(d_count), 32'd15); chk("flip_max", 32'(d_max), 32'd1);
        chk("flip_w1", 32'(d_wrap), 32'd0);
        d_up = 0;
        step(); chk("flip_dn", 32'(d_count), 32'd14); chk("flip_max2", 32'(d_max), 32'd0);
        chk("flip_w2", 32'(d_wrap), 32'd0);
        d_en = 0;

        // MODULO = 2**WIDTH at one bit: wrap every other cycle
        e_en = 1; e_up = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("m2_count", 32'(e_count), 32'(k % 2));
            chk("m2_wrap",  32'(e_wrap),  32'(k % 2 == 0));
        end
        e_en = 0;

        // Async reset mid-count, between edges
        a_load = 1; a_lv = 8'h55;
        step(); chk("ar_ld", 32'(a_count), 32'h55);
        a_load = 0; a_en = 1; a_up = 1;
        #3 rst = 1'b0;
        #1;
        chk("ar_count", 32'(a_count), 32'd0);
        chk("ar_wrap",  32'(a_wrap),  32'd0);
        chk("ar_zero",  32'(a_zero),  32'd1);
        step(); chk("ar_hold", 32'(a_count), 32'd0);
        rst = 1'b1;
        step(); chk("ar_rel", 32'(a_count), 32'd1);
        chk("ar_relz", 32'(a_zero), 32'd0);
        a_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
